// File: rtl/rx_deserializer.sv
// ----------------------------------------------------------------------------
// rx_deserializer
//
// Purpose:
//   UART-style serial receiver. The asynchronous rx line is synchronized,
//   a start bit is detected on a falling edge, and each bit is sampled in
//   the middle of its bit period. Data bits arrive LSB first, optionally
//   followed by a parity bit and then one or two stop bits. A finished word
//   is delivered through a single-entry holding register with a
//   valid/ready handshake. A frame that completes while the holding
//   register is still occupied is dropped and flagged with overrun_err.
//
// Ports:
//   clk          input              sole clock, rising edge
//   rst          input              synchronous active-high reset
//   rx           input              asynchronous serial line, idles high
//   rx_data      output [DW-1:0]    received word
//   rx_valid     output             rx_data / parity_err / frame_err valid
//   rx_ready     input              consumer accepts when rx_valid && rx_ready
//   parity_err   output             held word failed the parity check
//   frame_err    output             held word had a stop bit sampled low
//   overrun_err  output             one-cycle pulse, a completed frame was dropped
//   busy         output             receiver FSM is not idle
// ----------------------------------------------------------------------------
module rx_deserializer #(
    parameter int BAUD_DIV   = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int              CW          = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   FULL_RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]   HALF_RELOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
    localparam logic [2:0]      LAST_DATA   = 3'(DATA_WIDTH - 1);
    localparam logic            LAST_STOP   = 1'(STOP_BITS - 1);
    localparam logic            PAR_ODD     = (PARITY_ODD != 0);
    localparam logic            HAS_PARITY  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } stateT;

    stateT                  r_state;
    logic                   r_rxMeta;
    logic                   r_rxSync;
    logic                   r_rxPrev;
    logic [1:0]             r_fillCnt;
    logic                   r_armed;
    logic [CW-1:0]          r_baudCnt;
    logic [2:0]             r_bitIdx;
    logic                   r_stopIdx;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_parErr;
    logic                   r_frmErr;

    logic                   w_sample;
    logic                   w_fallEdge;
    logic                   w_stopErr;
    logic                   w_complete;
    logic                   w_holdFree;

    // Mid-bit sample strobe, start-bit edge detect, accumulated stop-bit
    // error including the current sample, and the end-of-frame condition.
    // An edge only counts once the line has been seen high after reset, so a
    // line held low through reset release is never mistaken for a start bit.
    assign w_sample   = (r_baudCnt == '0);
    assign w_fallEdge = r_armed && r_rxPrev && !r_rxSync;
    assign w_stopErr  = r_frmErr | ~r_rxSync;
    assign w_complete = (r_state == STOP) && w_sample && (r_stopIdx == LAST_STOP);
    assign w_holdFree = !rx_valid || rx_ready;
    assign busy       = (r_state != IDLE);

    // Two-flop synchronizer plus a delayed copy for edge detection. The
    // synchronizer resets to idle-high, so the first two samples after
    // reset are not real line values; r_fillCnt waits them out before a
    // genuine high level arms the start-bit detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxMeta  <= 1'b1;
            r_rxSync  <= 1'b1;
            r_rxPrev  <= 1'b1;
            r_fillCnt <= 2'd0;
            r_armed   <= 1'b0;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
            if (r_fillCnt != 2'd2) begin
                r_fillCnt <= r_fillCnt + 2'd1;
            end
            if ((r_fillCnt == 2'd2) && r_rxSync) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Receive FSM with its bit-period counter and shift register. The
    // counter is loaded with half a bit period on the start edge so that
    // every later sample lands in the middle of a bit, then reloads with a
    // full period at each sample point. A start bit that is high again at
    // its midpoint is treated as a glitch. A frame with a low stop bit parks
    // in BREAK until the line returns high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= 3'd0;
            r_stopIdx <= 1'b0;
            r_shift   <= '0;
            r_parErr  <= 1'b0;
            r_frmErr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fallEdge) begin
                        r_baudCnt <= HALF_RELOAD;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_sample) begin
                        r_baudCnt <= FULL_RELOAD;
                        if (!r_rxSync) begin
                            r_state   <= DATA;
                            r_bitIdx  <= 3'd0;
                            r_stopIdx <= 1'b0;
                            r_parErr  <= 1'b0;
                            r_frmErr  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_baudCnt <= FULL_RELOAD;
                        r_shift   <= {r_rxSync, r_shift[DATA_WIDTH-1:1]};
                        if (r_bitIdx == LAST_DATA) begin
                            r_state <= HAS_PARITY ? PARITY : STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt - CNT_ONE;
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        r_baudCnt <= FULL_RELOAD;
                        r_parErr  <= ((^r_shift) ^ r_rxSync) != PAR_ODD;
                        r_state   <= STOP;
                    end else begin
                        r_baudCnt <= r_baudCnt - CNT_ONE;
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        r_baudCnt <= FULL_RELOAD;
                        r_frmErr  <= w_stopErr;
                        if (r_stopIdx == LAST_STOP) begin
                            r_state <= w_stopErr ? BREAK : IDLE;
                        end else begin
                            r_stopIdx <= r_stopIdx + 1'b1;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt - CNT_ONE;
                    end
                end
                BREAK: begin
                    if (r_rxSync) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Single-entry holding register. A finished frame loads only when the
    // register is empty or being emptied in the same cycle; otherwise the
    // new frame is discarded, the held word stays untouched and overrun_err
    // pulses for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (w_complete && w_holdFree) begin
                rx_data    <= r_shift;
                parity_err <= r_parErr;
                frame_err  <= w_stopErr;
                rx_valid   <= 1'b1;
            end else begin
                if (w_complete) begin
                    overrun_err <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_rx_deserializer
//
// Directed bench for rx_deserializer at its default parameters (16 clocks
// per bit, 8 data bits, even parity, one stop bit). Frames are bit-banged
// onto rx with hand-chosen parity and stop values; a negedge monitor logs
// every accepted word and counts valid and overrun cycles, and the main
// sequence compares those against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_rx_deserializer;

    localparam int BIT_CLKS = 16;

    // Start edge to first visible rx_valid: 2 synchronizer flops, 1 cycle of
    // edge detect, half a bit to the start midpoint, then 10 more bits
    // (8 data, parity, stop) to the stop midpoint, plus the output register.
    localparam int FRAME_LATENCY = 2 + 1 + 8 + 16 * 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int         checkCount = 0;
    int         errorCount = 0;
    int         cyc = 0;
    int         acceptCount = 0;
    int         validCycles = 0;
    int         overrunCycles = 0;
    int         firstAcceptCyc = -1;
    int         startCyc = 0;
    logic [7:0] lastData = 8'h00;
    logic       lastPar = 1'b0;
    logic       lastFrm = 1'b0;
    logic       busySeen;
    logic [7:0] abortWord;

    rx_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    // Free-running clock and a cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Handshake monitor on the falling edge, where inputs and outputs are
    // both stable: records each accepted word and counts valid and overrun
    // cycles outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) validCycles++;
            if (overrun_err) overrunCycles++;
            if (rx_valid && rx_ready) begin
                acceptCount++;
                lastData = rx_data;
                lastPar  = parity_err;
                lastFrm  = frame_err;
                if (acceptCount == 1) firstAcceptCyc = cyc;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input logic v);
        rx = v;
        waitCycles(BIT_CLKS);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parBit,
                                 input logic stopBit);
        startCyc = cyc;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(parBit);
        driveBit(stopBit);
        rx = 1'b1;
    endtask

    // Main directed sequence.
    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        waitCycles(3);
        checkOutput("reset_valid",   rx_valid,    0);
        checkOutput("reset_data",    rx_data,     0);
        checkOutput("reset_parity",  parity_err,  0);
        checkOutput("reset_frame",   frame_err,   0);
        checkOutput("reset_overrun", overrun_err, 0);
        checkOutput("reset_busy",    busy,        0);
        rst = 1'b0;
        waitCycles(BIT_CLKS);

        $display("[TB] clean frame 0xA5");
        applyStimulus(8'hA5, 1'b0, 1'b1);
        waitCycles(BIT_CLKS);
        checkOutput("a5_count",   acceptCount, 1);
        checkOutput("a5_data",    lastData,    8'hA5);
        checkOutput("a5_parity",  lastPar,     0);
        checkOutput("a5_frame",   lastFrm,     0);
        checkOutput("a5_pulse",   validCycles, 1);
        checkOutput("a5_latency", firstAcceptCyc - startCyc, FRAME_LATENCY);

        $display("[TB] parity error frame 0x3C");
        applyStimulus(8'h3C, 1'b1, 1'b1);
        waitCycles(BIT_CLKS);
        checkOutput("3c_count",  acceptCount, 2);
        checkOutput("3c_data",   lastData,    8'h3C);
        checkOutput("3c_parity", lastPar,     1);
        checkOutput("3c_frame",  lastFrm,     0);

        $display("[TB] framing error 0x55 then clean 0x12");
        applyStimulus(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) driveBit(1'b1);
        checkOutput("55_count",  acceptCount, 3);
        checkOutput("55_data",   lastData,    8'h55);
        checkOutput("55_frame",  lastFrm,     1);
        checkOutput("55_parity", lastPar,     0);
        applyStimulus(8'h12, 1'b0, 1'b1);
        waitCycles(BIT_CLKS);
        checkOutput("12_count",  acceptCount, 4);
        checkOutput("12_data",   lastData,    8'h12);
        checkOutput("12_frame",  lastFrm,     0);
        checkOutput("12_parity", lastPar,     0);

        $display("[TB] start-bit glitch");
        rx = 1'b0;
        waitCycles(5);
        rx = 1'b1;
        waitCycles(2 * BIT_CLKS);
        checkOutput("glitch_count",   acceptCount,   4);
        checkOutput("glitch_valid",   validCycles,   4);
        checkOutput("glitch_overrun", overrunCycles, 0);
        checkOutput("glitch_busy",    busy,          0);

        $display("[TB] overrun with 0x11 then 0x22");
        rx_ready = 1'b0;
        applyStimulus(8'h11, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b1);
        waitCycles(BIT_CLKS);
        checkOutput("ovr_valid",   rx_valid,      1);
        checkOutput("ovr_data",    rx_data,       8'h11);
        checkOutput("ovr_pulses",  overrunCycles, 1);
        checkOutput("ovr_noaccept", acceptCount,  4);
        rx_ready = 1'b1;
        waitCycles(2);
        checkOutput("ovr_accept",  acceptCount, 5);
        checkOutput("ovr_lastdat", lastData,    8'h11);
        checkOutput("ovr_cleared", rx_valid,    0);

        $display("[TB] reset mid-frame");
        rx_ready = 1'b0;
        applyStimulus(8'h5A, 1'b0, 1'b1);
        waitCycles(BIT_CLKS);
        checkOutput("hold_valid", rx_valid, 1);
        checkOutput("hold_data",  rx_data,  8'h5A);
        abortWord = 8'h7E;
        driveBit(1'b0);
        for (int i = 0; i < 3; i++) driveBit(abortWord[i]);
        rx = abortWord[3];
        waitCycles(8);
        checkOutput("mid_busy", busy, 1);
        rst = 1'b1;
        waitCycles(2);
        checkOutput("rst_valid",   rx_valid,    0);
        checkOutput("rst_data",    rx_data,     0);
        checkOutput("rst_busy",    busy,        0);
        checkOutput("rst_overrun", overrun_err, 0);
        rst = 1'b0;
        rx  = 1'b1;
        waitCycles(2 * BIT_CLKS);
        rx_ready = 1'b1;
        applyStimulus(8'h81, 1'b0, 1'b1);
        waitCycles(BIT_CLKS);
        checkOutput("81_count",   acceptCount,   6);
        checkOutput("81_data",    lastData,      8'h81);
        checkOutput("81_frame",   lastFrm,       0);
        checkOutput("81_overrun", overrunCycles, 1);

        $display("[TB] line low through reset release");
        rx  = 1'b0;
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        busySeen = 1'b0;
        repeat (48) begin
            waitCycles(1);
            busySeen = busySeen | busy;
        end
        checkOutput("lowrst_busy",  busySeen,    0);
        checkOutput("lowrst_count", acceptCount, 6);
        rx = 1'b1;
        waitCycles(BIT_CLKS);
        applyStimulus(8'hC3, 1'b0, 1'b1);
        waitCycles(BIT_CLKS);
        checkOutput("c3_count", acceptCount, 7);
        checkOutput("c3_data",  lastData,    8'hC3);
        checkOutput("c3_frame", lastFrm,     0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rx_deserializer.md
RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
REQ-001 Parameter BAUD_DIV, default 16: clk cycles per UART bit; legal range 4..65535.
REQ-002 Parameter DATA_WIDTH, default 8: data bits per frame; legal range 5..8.
REQ-003 Parameter PARITY_EN, default 1: 1 = a parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even parity.
REQ-005 Parameter STOP_BITS, default 1: number of stop bits checked; legal values 1 and 2.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 rx  input  1  asynchronous serial line; idles high; LSB first.
REQ-009 rx_data  output  DATA_WIDTH  received word.
REQ-010 rx_valid  output  1  rx_data, parity_err and frame_err are valid.
REQ-011 rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
REQ-012 parity_err  output  1  held word failed the parity check.
REQ-013 frame_err  output  1  held word had a stop bit sampled low.
REQ-014 overrun_err  output  1  one-cycle pulse: a completed frame was dropped.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 rx passes through a 2-flop synchronizer (rx_s); all sampling uses rx_s.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-018 IDLE: a falling edge of rx_s (previous 1, current 0) loads the bit counter with BAUD_DIV/2-1 (integer division) and moves to START.
REQ-019 The bit counter decrements by 1 each cycle; a "sample point" is the cycle in which the counter equals 0, after which it reloads with BAUD_DIV-1.
REQ-020 START: at the sample point, rx_s=0 moves to DATA; rx_s=1 is a glitch, returns to IDLE and produces no output or error.
REQ-021 DATA: each sample point shifts rx_s into the MSB of the shift register, right-shifting (LSB-first line). After DATA_WIDTH samples the FSM moves to PARITY if PARITY_EN, else to STOP.
REQ-022 PARITY: the sample point computes the error as (XOR of data bits XOR rx_s) != PARITY_ODD, then moves to STOP.
REQ-023 STOP: each of the STOP_BITS sample points ORs (rx_s==0) into the frame error.
REQ-024 STOP, final sample point, frame error clear: frame complete, FSM returns to IDLE.
REQ-025 STOP, final sample point, frame error set: frame complete, FSM moves to BREAK; BREAK waits for rx_s=1, then goes to IDLE.
REQ-026 Frame complete with holding register free (rx_valid=0, or rx_valid && rx_ready in the same cycle): on the next edge, load rx_data and the parity and frame error flags, and set rx_valid.
REQ-027 Latency: rx_valid rises exactly 1 cycle after the final stop sample point.
REQ-028 Frame complete with holding register occupied and not accepted: discard the new frame; leave held data and flags unchanged; pulse overrun_err for exactly 1 cycle.
REQ-029 rx_valid && rx_ready clears rx_valid on the next edge unless a new word loads in that same edge (REQ-026); in that case rx_valid stays 1.
REQ-030 While rx_valid=1 and rx_ready=0, rx_data, parity_err and frame_err are stable.
REQ-031 The bit counter is width $clog2(BAUD_DIV); no wrap occurs outside the sample-point reload.
REQ-032 A new start bit is recognised on the cycle immediately after IDLE is re-entered (back-to-back frames).

Reset
REQ-033 While rst=1 at a clock edge, all of the following hold: FSM=IDLE, counters=0, synchronizer flops=1, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, busy=0.
REQ-034 Reset asserted mid-frame abandons the frame; no output is produced for it after reset deasserts.
REQ-035 A line held low when reset deasserts is not a start bit until a 1-to-0 edge is seen.

Verification
REQ-036 Defaults; send 0xA5, even parity bit 0, stop bit 1; rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5 and parity_err=0, frame_err=0.
REQ-037 Send 0x3C with parity bit 1 (wrong for even parity) -> rx_data=0x3C, parity_err=1.
REQ-038 Send 0x55 with stop bit 0, line then high for 3 bits -> frame_err=1; next frame 0x12 is received clean.
REQ-039 Drive rx low for 5 clks, then high -> no rx_valid, no errors, busy returns to 0.
REQ-040 rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11; overrun_err pulses once at completion of 0x22.
REQ-041 Assert rst during the 4th data bit of 0x7E, release, send 0x81 -> only 0x81 is delivered.
